// File: rtl/l2_write_buffer.sv
// Posted-write buffer between the L2 memory port and main memory: evictions are
// queued and drained in the background, and reads that hit a queued block are forwarded.
module l2_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    up_read,
    input  logic                    up_write,
    input  logic [27:0]             up_addr,
    input  logic [127:0]            up_wdata,
    output logic [127:0]            up_rdata,
    output logic                    up_ready,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [27:0]             mem_addr,
    output logic [127:0]            mem_wdata,
    input  logic [127:0]            mem_rdata,
    input  logic                    mem_ready,
    output logic [$clog2(DEPTH):0]  buf_count,
    output logic                    buf_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t           state, state_next;
    logic [DEPTH-1:0] valid;
    logic [27:0]      addr_q [DEPTH];
    logic [127:0]     data_q [DEPTH];
    logic [PW-1:0]    head, tail;
    logic [CW-1:0]    count;

    logic             hit;
    logic [PW-1:0]    hit_idx;
    logic             is_write, is_read, full;
    logic             wr_merge, wr_push, rd_fwd, rd_miss, rd_done, pop;
    logic             launch_read, launch_drain;

    // Walk from oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (valid[head + PW'(k)] && (addr_q[head + PW'(k)] == up_addr)) begin
                hit     = 1'b1;
                hit_idx = head + PW'(k);
            end
        end
    end

    assign is_write = up_write;
    assign is_read  = up_read && !up_write;
    assign full     = (count == CW'(DEPTH));
    // The in-flight head already has its data latched into mem_wdata, so it never merges.
    assign wr_merge = is_write && hit && !((state == DRAIN) && (hit_idx == head));
    assign wr_push  = is_write && !wr_merge && !full;
    assign rd_fwd   = is_read && hit;
    assign rd_miss  = is_read && !hit;
    assign rd_done  = (state == READ) && mem_ready;
    assign pop      = (state == DRAIN) && mem_ready;

    // NOTE: every output of a combinational block gets a default first; otherwise a latch is inferred.
    always_comb begin
        up_ready = 1'b0;
        up_rdata = '0;
        if (!reset) begin
            if (wr_merge || wr_push) begin
                up_ready = 1'b1;
            end else if (rd_fwd) begin
                up_ready = 1'b1;
                up_rdata = data_q[hit_idx];
            end else if (rd_miss && rd_done) begin
                up_ready = 1'b1;
                up_rdata = mem_rdata;
            end
        end
    end

    always_comb begin
        state_next   = state;
        launch_read  = 1'b0;
        launch_drain = 1'b0;
        case (state)
            IDLE: begin
                if (rd_miss) begin
                    launch_read = 1'b1;
                    state_next  = READ;
                end else if (count != '0) begin
                    launch_drain = 1'b1;
                    state_next   = DRAIN;
                end
            end
            READ, DRAIN: begin
                if (mem_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            valid     <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else begin
            state <= state_next;
            if (launch_read) begin
                mem_read <= 1'b1;
                mem_addr <= up_addr;
            end else if (launch_drain) begin
                mem_write <= 1'b1;
                mem_addr  <= addr_q[head];
                // A merge into the head in the launch cycle must reach memory, not the stale data.
                mem_wdata <= (wr_merge && (hit_idx == head)) ? up_wdata : data_q[head];
            end else if (rd_done || pop) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
            end
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + PW'(1);
            end
            if (wr_push) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PW'(1);
            end
            count <= count + CW'(wr_push) - CW'(pop);
        end
    end

    // NOTE: the entry storage has no reset; the valid bits alone decide what is live.
    always_ff @(posedge clk) begin
        if (wr_push) begin
            addr_q[tail] <= up_addr;
            data_q[tail] <= up_wdata;
        end else if (wr_merge) begin
            data_q[hit_idx] <= up_wdata;
        end
    end

    assign buf_count = count;
    assign buf_empty = (count == '0);

endmodule

// File: tb/tb_l2_write_buffer.sv
// Self-checking bench for l2_write_buffer: a queue-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_l2_write_buffer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    localparam logic [127:0] DA = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] DB = 128'hBBBB_0000_1111_2222_3333_4444_5555_6666;
    localparam logic [127:0] DC = 128'hCCCC_CCCC_0000_0000_1234_5678_9ABC_DEF0;
    localparam logic [127:0] DD = 128'hDDDD_1357_2468_ACE0_BDF1_0F0F_F0F0_5555;
    localparam logic [127:0] DE = 128'hEEEE_EEEE_EEEE_EEEE_0000_0000_0000_0001;
    localparam logic [127:0] DF = 128'hF00D_FACE_CAFE_BEEF_DEAD_C0DE_0BAD_F00D;
    localparam logic [127:0] RD50 = 128'h0000050_5A5A5A5A5A5A5A5A5A5A5A5A5;

    logic          clk = 1'b0;
    logic          reset;
    logic          up_read, up_write;
    logic [27:0]   up_addr;
    logic [127:0]  up_wdata, up_rdata;
    logic          up_ready;
    logic          mem_read, mem_write;
    logic [27:0]   mem_addr;
    logic [127:0]  mem_wdata;
    logic [127:0]  mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic [CW-1:0] buf_count;
    logic          buf_empty;

    l2_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .up_read(up_read), .up_write(up_write), .up_addr(up_addr),
        .up_wdata(up_wdata), .up_rdata(up_rdata), .up_ready(up_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .buf_count(buf_count), .buf_empty(buf_empty)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory responder: completes a request once it has been pending mem_lat cycles.
    logic hold_mem = 1'b0;
    int   mem_lat = 1;
    int   busy_cycles = 0;
    always @(posedge clk) begin
        #2;
        if (mem_read || mem_write) busy_cycles++;
        else busy_cycles = 0;
        mem_ready = !hold_mem && (mem_read || mem_write) && (busy_cycles >= mem_lat);
        mem_rdata = mem_read ? {mem_addr, 100'h5A5A5A5A5A5A5A5A5A5A5A5A5} : '0;
    end

    typedef struct { logic wr; logic [27:0] addr; logic [127:0] data; } op_t;
    op_t mem_log[$];

    // Reference model: an ordered list of buffered blocks plus the one outstanding memory request.
    typedef struct { logic [27:0] addr; logic [127:0] data; } ent_t;
    ent_t         model_q[$];
    int           model_busy;   // 0 none, 1 read outstanding, 2 drain outstanding
    logic [27:0]  model_maddr;
    logic [127:0] model_mwdata;
    logic         prev_strobe;

    initial begin
        int           hit, pre_size;
        logic         e_ready, e_miss;
        logic [127:0] e_rdata;
        model_busy   = 0;
        model_maddr  = '0;
        model_mwdata = '0;
        prev_strobe  = 1'b0;
        forever begin
            @(negedge clk);
            if ((mem_read || mem_write) && !prev_strobe)
                mem_log.push_back('{mem_write, mem_addr, mem_wdata});
            prev_strobe = mem_read || mem_write;
            if (reset) begin
                model_q.delete();
                model_busy   = 0;
                model_maddr  = '0;
                model_mwdata = '0;
            end
            pre_size = model_q.size();
            hit = -1;
            for (int i = pre_size - 1; i >= 0; i--) begin
                if (hit < 0 && model_q[i].addr == up_addr) hit = i;
            end
            e_ready = 1'b0;
            e_rdata = '0;
            e_miss  = 1'b0;
            if (!reset) begin
                if (up_write) begin
                    if (hit >= 0 && !(model_busy == 2 && hit == 0)) begin
                        model_q[hit].data = up_wdata;
                        e_ready = 1'b1;
                    end else if (pre_size < DEPTH) begin
                        model_q.push_back('{up_addr, up_wdata});
                        e_ready = 1'b1;
                    end
                end else if (up_read) begin
                    if (hit >= 0) begin
                        e_ready = 1'b1;
                        e_rdata = model_q[hit].data;
                    end else begin
                        e_miss = 1'b1;
                        if (model_busy == 1 && mem_ready) begin
                            e_ready = 1'b1;
                            e_rdata = mem_rdata;
                        end
                    end
                end
            end
            check("up_ready",  128'(up_ready),  128'(e_ready));
            check("up_rdata",  up_rdata,        e_rdata);
            check("mem_read",  128'(mem_read),  128'(model_busy == 1));
            check("mem_write", 128'(mem_write), 128'(model_busy == 2));
            check("mem_addr",  128'(mem_addr),  128'(model_maddr));
            check("mem_wdata", mem_wdata,       model_mwdata);
            check("buf_count", 128'(buf_count), 128'(pre_size));
            check("buf_empty", 128'(buf_empty), 128'(pre_size == 0));
            if (!reset) begin
                if (model_busy == 0) begin
                    if (e_miss) begin
                        model_busy  = 1;
                        model_maddr = up_addr;
                    end else if (pre_size > 0) begin
                        model_busy   = 2;
                        model_maddr  = model_q[0].addr;
                        model_mwdata = model_q[0].data;
                    end
                end else if (mem_ready) begin
                    if (model_busy == 2) void'(model_q.pop_front());
                    model_busy = 0;
                end
            end
        end
    end

    task automatic do_req(input string name, input logic rd, input logic wr, input logic [27:0] a,
                          input logic [127:0] d, input int budget, output logic [127:0] rdata);
        int waited = 0;
        up_read  = rd;
        up_write = wr;
        up_addr  = a;
        up_wdata = d;
        forever begin
            @(negedge clk);
            if (up_ready || waited >= budget) break;
            waited++;
            @(posedge clk); #1;
        end
        check({name, "_ready"}, 128'(up_ready), 128'd1);
        rdata = up_rdata;
        @(posedge clk); #1;
        up_read  = 1'b0;
        up_write = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(buf_empty && !mem_write && !mem_read) && n < budget);
        check({name, "_idle"}, 128'({buf_empty, mem_write, mem_read}), 128'(3'b100));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [127:0] rd;
        reset = 1'b1; up_read = 1'b0; up_write = 1'b0; up_addr = '0; up_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_up_ready",  128'(up_ready),  128'd0);
        check("rst_up_rdata",  up_rdata,        128'd0);
        check("rst_mem_read",  128'(mem_read),  128'd0);
        check("rst_mem_write", 128'(mem_write), 128'd0);
        check("rst_buf_count", 128'(buf_count), 128'd0);
        check("rst_buf_empty", 128'(buf_empty), 128'd1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single write, then background drain.
        do_req("wr_a", 1'b0, 1'b1, 28'h0000010, DA, 4, rd);
        @(negedge clk);
        check("wr_a_count", 128'(buf_count), 128'd1);
        check("wr_a_no_strobe_yet", 128'(mem_write), 128'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("drain_a_strobe", 128'(mem_write), 128'd1);
        check("drain_a_addr", 128'(mem_addr), 128'h0000010);
        check("drain_a_data", mem_wdata, DA);
        @(posedge clk); #1;
        @(negedge clk);
        check("drain_a_count", 128'(buf_count), 128'd0);
        check("drain_a_empty", 128'(buf_empty), 128'd1);
        @(posedge clk); #1;

        // Forwarding from a buffered (in-flight) block.
        hold_mem = 1'b1;
        do_req("wr_b", 1'b0, 1'b1, 28'h0000020, DB, 4, rd);
        do_req("rd_b", 1'b1, 1'b0, 28'h0000020, '0, 4, rd);
        check("fwd_data", rd, DB);
        @(negedge clk);
        check("fwd_no_mem_read", 128'(mem_read), 128'd0);
        hold_mem = 1'b0;
        wait_idle("fwd", 20);

        // Merge into a non-in-flight entry; same-address write behind the in-flight head enqueues.
        mem_log.delete();
        hold_mem = 1'b1;
        do_req("wr_c", 1'b0, 1'b1, 28'h0000030, DC, 4, rd);
        do_req("wr_d", 1'b0, 1'b1, 28'h0000040, DD, 4, rd);
        do_req("wr_e", 1'b0, 1'b1, 28'h0000030, DE, 4, rd);
        do_req("wr_f", 1'b0, 1'b1, 28'h0000040, DF, 4, rd);
        @(negedge clk);
        check("merge_count", 128'(buf_count), 128'd3);
        @(posedge clk); #1;
        hold_mem = 1'b0;
        wait_idle("merge", 40);
        check("merge_log_n", 128'(mem_log.size()), 128'd3);
        if (mem_log.size() == 3) begin
            check("merge_op0_addr", 128'(mem_log[0].addr), 128'h30);
            check("merge_op0_data", mem_log[0].data, DC);
            check("merge_op1_addr", 128'(mem_log[1].addr), 128'h40);
            check("merge_op1_data", mem_log[1].data, DF);
            check("merge_op2_addr", 128'(mem_log[2].addr), 128'h30);
            check("merge_op2_data", mem_log[2].data, DE);
        end

        // Full buffer: fifth write waits, refused in the pop cycle, accepted the cycle after.
        mem_log.delete();
        hold_mem = 1'b1;
        for (int i = 0; i < DEPTH; i++)
            do_req("wr_full", 1'b0, 1'b1, 28'h0000100 + 28'(i), DA ^ 128'(i), 4, rd);
        up_write = 1'b1;
        up_addr  = 28'h0000104;
        up_wdata = DF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_wait", 128'(up_ready), 128'd0);
            @(posedge clk); #1;
        end
        hold_mem = 1'b0;
        @(negedge clk);
        check("full_pop_cycle_ready", 128'(up_ready), 128'd0);
        check("full_pop_cycle_count", 128'(buf_count), 128'd4);
        @(posedge clk); #1;
        @(negedge clk);
        check("full_accept_ready", 128'(up_ready), 128'd1);
        check("full_accept_count", 128'(buf_count), 128'd3);
        @(posedge clk); #1;
        up_write = 1'b0;
        wait_idle("full", 60);
        check("full_log_n", 128'(mem_log.size()), 128'd5);
        if (mem_log.size() == 5) begin
            check("full_last_addr", 128'(mem_log[4].addr), 128'h104);
            check("full_last_data", mem_log[4].data, DF);
        end

        // Read miss takes priority over pending drains once IDLE is reached.
        mem_log.delete();
        hold_mem = 1'b1;
        mem_lat  = 3;
        do_req("wr_p0", 1'b0, 1'b1, 28'h0000200, DA, 4, rd);
        do_req("wr_p1", 1'b0, 1'b1, 28'h0000201, DB, 4, rd);
        do_req("wr_p2", 1'b0, 1'b1, 28'h0000202, DC, 4, rd);
        hold_mem = 1'b0;
        do_req("rd_miss", 1'b1, 1'b0, 28'h0000050, '0, 30, rd);
        check("miss_data", rd, RD50);
        wait_idle("miss", 80);
        check("miss_log_n", 128'(mem_log.size()), 128'd4);
        if (mem_log.size() == 4) begin
            check("miss_op0", 128'({mem_log[0].wr, mem_log[0].addr}), 128'({1'b1, 28'h200}));
            check("miss_op1", 128'({mem_log[1].wr, mem_log[1].addr}), 128'({1'b0, 28'h050}));
            check("miss_op2", 128'({mem_log[2].wr, mem_log[2].addr}), 128'({1'b1, 28'h201}));
            check("miss_op3", 128'({mem_log[3].wr, mem_log[3].addr}), 128'({1'b1, 28'h202}));
        end
        mem_lat = 1;

        // Reset in the middle of a drain discards everything.
        hold_mem = 1'b1;
        do_req("wr_r", 1'b0, 1'b1, 28'h0000300, DD, 4, rd);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid_strobe", 128'(mem_write), 128'd1);
        @(posedge clk); #1;
        reset    = 1'b1;
        up_write = 1'b1;
        up_addr  = 28'h0000310;
        up_wdata = DE;
        @(negedge clk);
        check("rst_mid_mem_write", 128'(mem_write), 128'd0);
        check("rst_mid_mem_wdata", mem_wdata, 128'd0);
        check("rst_mid_count", 128'(buf_count), 128'd0);
        check("rst_mid_up_ready", 128'(up_ready), 128'd0);
        @(posedge clk); #1;
        reset    = 1'b0;
        up_write = 1'b0;
        hold_mem = 1'b0;
        @(negedge clk);
        check("post_rst_strobes", 128'({mem_read, mem_write}), 128'd0);
        check("post_rst_empty", 128'(buf_empty), 128'd1);
        @(posedge clk); #1;

        do_req("wr_rec", 1'b0, 1'b1, 28'h0000400, DA, 4, rd);
        wait_idle("recover", 20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, errors=%0d", n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
